tetris_row_clear: RTL

- Line-clear engine upstream of the playfield display; it compacts the board RAM that the display scans.
- On `start`, scans board rows from bottom to top and drops every full row. Surviving rows move down; vacated top rows are zero-filled.
- Reports the number of rows cleared. Owns the board RAM's Avalon-side port (port A) while `busy`; an external mux grants the port.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/tetris_score_acc.sv | 37 +++
 rtl/tetris_row_clear.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris line-clear engine.
//   DEF_ROWS / DEF_COLS : default playfield geometry
//   row_clr_state_t     : line-clear FSM states
//   SCORE_TBL           : points per pass indexed by min(lines,4)
//   is_full_row()       : true when the low `cols` bits of a row word are all set
package tetris_pkg;

  localparam int unsigned DEF_ROWS = 20;
  localparam int unsigned DEF_COLS = 10;
  localparam int unsigned SCORE_W  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EVAL  = 3'd2,
    WRITE = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5
  } row_clr_state_t;

  localparam logic [SCORE_W-1:0] SCORE_TBL [5] = '{24'd0, 24'd40, 24'd100, 24'd300, 24'd1200};

  function automatic logic is_full_row(input logic [31:0] word, input int unsigned cols);
    logic full;
    full = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i < cols) && !word[i]) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/tetris_score_acc.sv
// Saturating score accumulator for the line-clear engine.
// Only instantiated when TETRIS_ROW_CLEAR_SCORE_EN is defined.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset (clears score)
//   add        : one-cycle strobe, adds the table value for `lines`
//   lines      : rows cleared by the pass just finished
//   score      : cumulative score, saturates at all ones
module tetris_score_acc
  import tetris_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               add,
  input  logic [CNT_W-1:0]   lines,
  output logic [SCORE_W-1:0] score
);

  logic [2:0]       idx;
  logic [SCORE_W:0] sum;

  // Table index clamps at four lines; extra bit of the sum flags overflow.
  always_comb begin
    idx = (lines > CNT_W'(4)) ? 3'd4 : 3'(lines);
    sum = {1'b0, score} + {1'b0, SCORE_TBL[idx]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      score <= '0;
    end else if (add) begin
      score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/tetris_row_clear.sv
// Line-clear engine: scans the board RAM bottom to top, drops full rows,
// shifts survivors down and zero-fills the vacated top rows.
// Optional scoring is enabled by defining TETRIS_ROW_CLEAR_SCORE_EN.
// Ports:
//   CLK, RESET     : clock, synchronous active-high reset
//   start          : request a pass (sampled in IDLE only)
//   busy, done     : pass in progress / one-cycle completion pulse
//   lines_cleared  : full rows removed by the last pass
//   mem_*          : board RAM port A (read data valid the cycle after mem_rden)
//   score          : cumulative score (zero when scoring is disabled)
module tetris_row_clear
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  lines_cleared,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [23:0]       score
);

  row_clr_state_t    state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rows_left_q, rows_left_d;

  logic              busy_d, done_d, mem_rden_d, mem_wren_d;
  logic [CNT_W-1:0]  lines_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;

  // Where the scan goes once the current row has been fully handled.
  function automatic row_clr_state_t after_row(input logic [CNT_W-1:0] left,
                                               input logic [CNT_W-1:0] n);
    if (left != '0) return READ;
    if (n != '0)    return FILL;
    return DONE;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      rows_left_q   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      mem_addr      <= '0;
      mem_rden      <= 1'b0;
      mem_wren      <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      rows_left_q   <= rows_left_d;
      busy          <= busy_d;
      done          <= done_d;
      lines_cleared <= lines_d;
      mem_addr      <= mem_addr_d;
      mem_rden      <= mem_rden_d;
      mem_wren      <= mem_wren_d;
      mem_wdata     <= mem_wdata_d;
    end
  end

  // Next state and pointers; outputs are precomputed from the next state so
  // the registered port values line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    rows_left_d = rows_left_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d    = ADDR_W'(ROWS - 1);
          wr_ptr_d    = ADDR_W'(ROWS - 1);
          cnt_d       = '0;
          rows_left_d = CNT_W'(ROWS);
          state_d     = READ;
        end
      end
      READ: state_d = EVAL;
      EVAL: begin
        rd_ptr_d    = rd_ptr_q - ADDR_W'(1);
        rows_left_d = rows_left_q - CNT_W'(1);
        if (is_full_row(mem_rdata, COLS)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = after_row(rows_left_d, cnt_d);
        end else if (wr_ptr_q != rd_ptr_q) begin
          state_d = WRITE;
        end else begin
          wr_ptr_d = wr_ptr_q - ADDR_W'(1);
          state_d  = after_row(rows_left_d, cnt_d);
        end
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q - ADDR_W'(1);
        state_d  = after_row(rows_left_q, cnt_q);
      end
      // After the scan wr_ptr sits at cnt-1, so filling down to row 0 writes cnt rows.
      FILL: begin
        wr_ptr_d = wr_ptr_q - ADDR_W'(1);
        state_d  = (wr_ptr_q == '0) ? DONE : FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    mem_rden_d = (state_d == READ);
    mem_wren_d = (state_d == WRITE) || (state_d == FILL);
    lines_d    = (state_d == DONE) ? cnt_d : lines_cleared;

    mem_addr_d = '0;
    if (state_d == READ)    mem_addr_d = rd_ptr_d;
    else if (mem_wren_d)    mem_addr_d = wr_ptr_d;

    // WRITE is only entered from EVAL, so the live read word is the one to move.
    mem_wdata_d = (state_d == WRITE) ? mem_rdata : 32'd0;
  end

`ifdef TETRIS_ROW_CLEAR_SCORE_EN
  tetris_score_acc #(
    .CNT_W (CNT_W)
  ) u_score (
    .CLK   (CLK),
    .RESET (RESET),
    .add   (done),
    .lines (cnt_q),
    .score (score)
  );
`else
  assign score = '0;
`endif

endmodule
